// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: core vs aux (loader/DMA) with starvation-driven priority flip.
// Optional statistics counters enabled by defining DMEM_ARBITER_STATS_EN.
module dmem_arbiter #(
  parameter int unsigned AUX_WAIT_MAX = 8,
  parameter int unsigned AUX_BURST    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [2:0]  core_s_ctrl,
  input  logic [2:0]  core_i_ctrl,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  input  logic        aux_valid,
  input  logic        aux_we,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  output logic        aux_ready,
  output logic [31:0] aux_rdata,
  output logic        aux_rvalid,
  output logic        d_write_en,
  output logic [31:0] d_addr,
  output logic [31:0] d_write_data,
  output logic [2:0]  s_type_controls,
  output logic [2:0]  i_type_controls,
  input  logic [31:0] d_read_data,
  output logic [15:0] stat_stall_cnt,
  output logic [15:0] stat_aux_cnt
);

  typedef enum logic {
    CORE_PRI = 1'b0,
    AUX_PRI  = 1'b1
  } state_t;

  localparam logic [7:0] LP_WAIT_MAX = 8'(AUX_WAIT_MAX);
  localparam logic [7:0] LP_BURST    = 8'(AUX_BURST);
  localparam logic [2:0] LP_WORD     = 3'b010;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_wait;
  logic [7:0]  w_wait_nxt;
  logic [7:0]  w_wait_inc;
  logic [7:0]  r_burst;
  logic [7:0]  w_burst_nxt;
  logic [7:0]  w_burst_inc;
  logic        w_aux_gnt;
  logic        w_core_gnt;
  logic        r_aux_rvalid;
  logic [31:0] r_aux_rdata;

  // Grants are forced low in reset so nothing reaches memory.
  always_comb begin
    w_aux_gnt  = 1'b0;
    w_core_gnt = 1'b0;
    if (rst) begin
      unique case (r_state)
        CORE_PRI: begin
          w_core_gnt = core_req;
          w_aux_gnt  = aux_valid & ~core_req;
        end
        AUX_PRI: begin
          w_aux_gnt  = aux_valid;
          w_core_gnt = core_req & ~aux_valid;
        end
      endcase
    end
  end

  assign aux_ready  = w_aux_gnt;
  assign core_stall = core_req & w_aux_gnt;
  assign core_rdata = d_read_data;

  always_comb begin
    d_write_en      = 1'b0;
    d_addr          = core_addr;
    d_write_data    = core_wdata;
    s_type_controls = core_s_ctrl;
    i_type_controls = core_i_ctrl;
    unique case (1'b1)
      w_aux_gnt: begin
        d_write_en      = aux_we;
        d_addr          = aux_addr;
        d_write_data    = aux_wdata;
        s_type_controls = LP_WORD;
        i_type_controls = LP_WORD;
      end
      w_core_gnt: begin
        d_write_en = core_we;
      end
      default: begin
        d_write_en = 1'b0;
      end
    endcase
  end

  assign w_wait_inc  = (r_wait == 8'hFF) ? r_wait : r_wait + 8'd1;
  assign w_burst_inc = (r_burst == 8'hFF) ? r_burst : r_burst + 8'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_burst_nxt = r_burst;
    unique case (r_state)
      CORE_PRI: begin
        w_burst_nxt = 8'd0;
        if (!aux_valid || w_aux_gnt) begin
          w_wait_nxt = 8'd0;
        end else if (w_wait_inc >= LP_WAIT_MAX) begin
          w_state_nxt = AUX_PRI;
          w_wait_nxt  = 8'd0;
        end else begin
          w_wait_nxt = w_wait_inc;
        end
      end
      AUX_PRI: begin
        w_wait_nxt = 8'd0;
        if (!aux_valid) begin
          w_state_nxt = CORE_PRI;
          w_burst_nxt = 8'd0;
        end else if (w_burst_inc >= LP_BURST) begin
          w_state_nxt = CORE_PRI;
          w_burst_nxt = 8'd0;
        end else begin
          w_burst_nxt = w_burst_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= CORE_PRI;
      r_wait  <= 8'd0;
      r_burst <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      r_burst <= w_burst_nxt;
    end
  end

  // Aux read response: one-cycle pulse with data captured at accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_aux_rvalid <= 1'b0;
      r_aux_rdata  <= 32'd0;
    end else begin
      r_aux_rvalid <= w_aux_gnt & ~aux_we;
      if (w_aux_gnt && !aux_we) begin
        r_aux_rdata <= d_read_data;
      end
    end
  end

  assign aux_rvalid = r_aux_rvalid;
  assign aux_rdata  = r_aux_rdata;

`ifdef DMEM_ARBITER_STATS_EN
  logic [15:0] r_stat_stall;
  logic [15:0] r_stat_aux;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_stall <= 16'd0;
      r_stat_aux   <= 16'd0;
    end else begin
      if (core_stall && r_stat_stall != 16'hFFFF) begin
        r_stat_stall <= r_stat_stall + 16'd1;
      end
      if (w_aux_gnt && r_stat_aux != 16'hFFFF) begin
        r_stat_aux <= r_stat_aux + 16'd1;
      end
    end
  end

  assign stat_stall_cnt = r_stat_stall;
  assign stat_aux_cnt   = r_stat_aux;
`else
  assign stat_stall_cnt = 16'd0;
  assign stat_aux_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, directed corner sequences,
// and randomized traffic against a priority/starvation reference model.
module tb_dmem_arbiter;

  localparam int WMAX = 8;
  localparam int BMAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic [2:0]  core_s_ctrl, core_i_ctrl;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        aux_valid, aux_we;
  logic [31:0] aux_addr, aux_wdata;
  logic        aux_ready;
  logic [31:0] aux_rdata;
  logic        aux_rvalid;
  logic        d_write_en;
  logic [31:0] d_addr, d_write_data;
  logic [2:0]  s_type_controls, i_type_controls;
  logic [31:0] d_read_data;
  logic [15:0] stat_stall_cnt, stat_aux_cnt;

  int checks = 0;
  int failures = 0;

  dmem_arbiter #(.AUX_WAIT_MAX(WMAX), .AUX_BURST(BMAX)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_s_ctrl(core_s_ctrl), .core_i_ctrl(core_i_ctrl),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .aux_valid(aux_valid), .aux_we(aux_we),
    .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_ready(aux_ready), .aux_rdata(aux_rdata),
    .aux_rvalid(aux_rvalid),
    .d_write_en(d_write_en), .d_addr(d_addr),
    .d_write_data(d_write_data),
    .s_type_controls(s_type_controls),
    .i_type_controls(i_type_controls),
    .d_read_data(d_read_data),
    .stat_stall_cnt(stat_stall_cnt), .stat_aux_cnt(stat_aux_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h20) return 32'h1234_5678;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign d_read_data = memf(d_addr);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic idle();
    core_req    = 1'b0;
    core_we     = 1'b0;
    core_addr   = 32'h0;
    core_wdata  = 32'h0;
    core_s_ctrl = 3'b000;
    core_i_ctrl = 3'b100;
    aux_valid   = 1'b0;
    aux_we      = 1'b0;
    aux_addr    = 32'h0;
    aux_wdata   = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic        cr, cwe, av, awe;
    logic [31:0] caddr, aaddr;
    logic        e_we, e_ready, e_stall;
    logic [31:0] e_addr, e_wdata;
    logic [2:0]  e_sctl, e_ictl;
  } vec_t;

  vec_t vt[6];

  // reference model state
  int          m_denied, m_won;
  bit          m_aux_first;
  bit          m_rv;
  logic [31:0] m_rd;
  bit          hold;

  initial begin
    vt[0] = '{1,1,0,0, 32'h10,32'h40, 1,0,0, 32'h10,32'hDEADBEEF, 3'b000,3'b100};
    vt[1] = '{1,0,0,0, 32'h10,32'h40, 0,0,0, 32'h10,32'hDEADBEEF, 3'b000,3'b100};
    vt[2] = '{0,0,1,1, 32'h10,32'h40, 1,1,0, 32'h40,32'hCAFEF00D, 3'b010,3'b010};
    vt[3] = '{0,0,1,0, 32'h10,32'h44, 0,1,0, 32'h44,32'hCAFEF00D, 3'b010,3'b010};
    vt[4] = '{1,1,1,1, 32'h14,32'h40, 1,0,0, 32'h14,32'hDEADBEEF, 3'b000,3'b100};
    vt[5] = '{0,1,0,0, 32'h18,32'h40, 0,0,0, 32'h18,32'hDEADBEEF, 3'b000,3'b100};

    // reset-state checks with all requests asserted
    idle();
    #12;
    core_req = 1; core_we = 1; aux_valid = 1; aux_we = 1;
    #1;
    chk("rst_d_write_en", 32'(d_write_en), 0);
    chk("rst_aux_ready", 32'(aux_ready), 0);
    chk("rst_core_stall", 32'(core_stall), 0);
    chk("rst_aux_rvalid", 32'(aux_rvalid), 0);
    chk("rst_aux_rdata", aux_rdata, 0);
    chk("rst_stat_stall", 32'(stat_stall_cnt), 0);
    chk("rst_stat_aux", 32'(stat_aux_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    idle();

    // vector table, each followed by an idle cycle
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      core_req = vt[i].cr; core_we = vt[i].cwe;
      core_addr = vt[i].caddr; core_wdata = 32'hDEADBEEF;
      aux_valid = vt[i].av; aux_we = vt[i].awe;
      aux_addr = vt[i].aaddr; aux_wdata = 32'hCAFEF00D;
      #1;
      chk($sformatf("v%0d_we", i), 32'(d_write_en), 32'(vt[i].e_we));
      chk($sformatf("v%0d_ready", i), 32'(aux_ready), 32'(vt[i].e_ready));
      chk($sformatf("v%0d_stall", i), 32'(core_stall), 32'(vt[i].e_stall));
      chk($sformatf("v%0d_addr", i), d_addr, vt[i].e_addr);
      chk($sformatf("v%0d_wdata", i), d_write_data, vt[i].e_wdata);
      chk($sformatf("v%0d_sctl", i), 32'(s_type_controls), 32'(vt[i].e_sctl));
      chk($sformatf("v%0d_ictl", i), 32'(i_type_controls), 32'(vt[i].e_ictl));
      chk($sformatf("v%0d_rdata", i), core_rdata, memf(vt[i].e_addr));
      @(negedge clk);
      idle();
    end

    // aux-only read of 0x20
    @(negedge clk);
    aux_valid = 1; aux_we = 0; aux_addr = 32'h20;
    #1;
    chk("rd_ready", 32'(aux_ready), 1);
    @(negedge clk);
    idle();
    #1;
    chk("rd_rvalid", 32'(aux_rvalid), 1);
    chk("rd_rdata", aux_rdata, 32'h1234_5678);
    @(negedge clk);
    #1;
    chk("rd_rvalid_pulse", 32'(aux_rvalid), 0);

    // continuous contention: 8 denied, 4 granted, repeat
    do_reset();
    core_req = 1; core_we = 0; core_addr = 32'h100;
    aux_valid = 1; aux_we = 1; aux_addr = 32'h200;
    for (int c = 0; c < 24; c++) begin
      #1;
      chk($sformatf("cont%0d_ready", c), 32'(aux_ready), 32'((c % 12) >= 8));
      chk($sformatf("cont%0d_stall", c), 32'(core_stall), 32'((c % 12) >= 8));
      @(negedge clk);
    end
    idle();
    #1;
`ifdef DMEM_ARBITER_STATS_EN
    chk("stat_stall", 32'(stat_stall_cnt), 8);
    chk("stat_aux", 32'(stat_aux_cnt), 8);
`else
    chk("stat_stall", 32'(stat_stall_cnt), 0);
    chk("stat_aux", 32'(stat_aux_cnt), 0);
`endif

    // reset right after an accepted read drops the response
    do_reset();
    aux_valid = 1; aux_we = 0; aux_addr = 32'h20;
    #1;
    chk("rr_ready", 32'(aux_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    #1;
    chk("rr_rvalid_in_rst", 32'(aux_rvalid), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("rr_rvalid_post%0d", c), 32'(aux_rvalid), 0);
      @(negedge clk);
    end
    core_req = 1; aux_valid = 1; aux_we = 1;
    #1;
    chk("rr_state_ready", 32'(aux_ready), 0);
    chk("rr_state_stall", 32'(core_stall), 0);

    // randomized traffic against the reference model
    do_reset();
    m_denied = 0; m_won = 0; m_aux_first = 0;
    m_rv = 0; m_rd = 32'h0;
    hold = 0;
    for (int n = 0; n < 600; n++) begin
      bit          e_gnt;
      logic [31:0] e_addr;
      core_req   = ($urandom_range(0, 3) != 0);
      core_we    = $urandom_range(0, 1);
      core_addr  = {$urandom_range(0, 255), 2'b00};
      core_wdata = $urandom;
      core_s_ctrl = 3'($urandom_range(0, 7));
      core_i_ctrl = 3'($urandom_range(0, 7));
      if (!hold) begin
        aux_valid = ($urandom_range(0, 3) != 0);
        aux_we    = $urandom_range(0, 1);
        aux_addr  = {$urandom_range(0, 255), 2'b00};
        aux_wdata = $urandom;
      end
      e_gnt  = aux_valid && (m_aux_first || !core_req);
      e_addr = e_gnt ? aux_addr : core_addr;
      #1;
      chk("rnd_ready", 32'(aux_ready), 32'(e_gnt));
      chk("rnd_stall", 32'(core_stall), 32'(core_req && e_gnt));
      chk("rnd_we", 32'(d_write_en),
          32'(e_gnt ? aux_we : (core_req && core_we)));
      chk("rnd_addr", d_addr, e_addr);
      chk("rnd_wdata", d_write_data, e_gnt ? aux_wdata : core_wdata);
      chk("rnd_sctl", 32'(s_type_controls),
          32'(e_gnt ? 3'b010 : core_s_ctrl));
      chk("rnd_rvalid", 32'(aux_rvalid), 32'(m_rv));
      chk("rnd_rdata", aux_rdata, m_rd);
      hold = aux_valid && !e_gnt;
      @(posedge clk);
      m_rv = e_gnt && !aux_we;
      if (m_rv) m_rd = memf(aux_addr);
      if (!m_aux_first) begin
        if (aux_valid && !e_gnt) begin
          m_denied++;
          if (m_denied == WMAX) begin
            m_aux_first = 1;
            m_denied = 0;
          end
        end else begin
          m_denied = 0;
        end
      end else if (!aux_valid) begin
        m_aux_first = 0;
        m_won = 0;
      end else begin
        m_won++;
        if (m_won == BMAX) begin
          m_aux_first = 0;
          m_won = 0;
        end
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AUX_WAIT_MAX, default 8: consecutive aux-denied cycles before priority flips to aux (range 1-255).
REQ-002 Parameter AUX_BURST, default 4: maximum consecutive aux grants while in AUX_PRI (range 1-255).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 core_req  in  1  core load/store this cycle.
REQ-006 core_we  in  1  core store (valid with core_req).
REQ-007 core_addr, core_wdata  in  32 each  core address and store data.
REQ-008 core_s_ctrl, core_i_ctrl  in  3 each  core store and load width controls (funct3).
REQ-009 core_rdata  out  32  load data to core.
REQ-010 core_stall  out  1  core access not serviced this cycle; PC and register writes hold.
REQ-011 aux_valid, aux_we  in  1 each  aux (loader/DMA) request and write flag.
REQ-012 aux_addr, aux_wdata  in  32 each  aux word address and write data.
REQ-013 aux_ready  out  1  aux request accepted this cycle.
REQ-014 aux_rdata  out  32  aux read data, registered.
REQ-015 aux_rvalid  out  1  one-cycle pulse qualifying aux_rdata.
REQ-016 d_write_en, d_addr, d_write_data, s_type_controls, i_type_controls  out  1/32/32/3/3  data-memory port.
REQ-017 d_read_data  in  32  data-memory combinational read data.
REQ-018 stat_stall_cnt, stat_aux_cnt  out  16 each  statistics (see Configuration).

Function
REQ-019 FSM states CORE_PRI and AUX_PRI; grant is combinational from state, core_req, aux_valid.
REQ-020 CORE_PRI: core_req granted whenever asserted; aux granted only when core_req=0.
REQ-021 AUX_PRI: aux granted whenever aux_valid=1; core granted only when aux_valid=0.
REQ-022 Aux handshake: transfer occurs when aux_valid and aux_ready are both 1; aux_ready is 1 exactly when aux is granted; aux holds its request fields stable until accepted.
REQ-023 core_stall = core_req AND aux granted; it is never 1 when core_req=0.
REQ-024 Memory port driven by granted requester; no grant -> d_write_en=0 and other outputs drive core values.
REQ-025 Aux access always uses word width: s_type_controls=3'b010, i_type_controls=3'b010.
REQ-026 core_rdata = d_read_data combinationally, every cycle.
REQ-027 Accepted aux read (aux_we=0): aux_rdata registers d_read_data and aux_rvalid=1 the next cycle only; aux writes produce no rvalid.
REQ-028 Wait counter (8-bit) increments each CORE_PRI cycle with aux_valid=1 and aux not granted; it clears on any aux grant or aux_valid=0.
REQ-029 Wait counter reaching AUX_WAIT_MAX -> next state AUX_PRI, wait counter cleared.
REQ-030 Burst counter (8-bit) increments per aux grant in AUX_PRI; reaching AUX_BURST, or aux_valid=0 in AUX_PRI -> next state CORE_PRI, burst counter cleared.
REQ-031 Simultaneous core_req and aux_valid with no pending flip: state alone decides; no cycle has both requesters granted.
REQ-032 Counters saturate and never wrap.

Reset
REQ-033 rst low, asynchronously: state CORE_PRI, all counters 0, aux_rdata 0, aux_rvalid 0.
REQ-034 While rst is low, d_write_en=0, aux_ready=0, and core_stall=0 regardless of inputs.
REQ-035 Reset during an aux read drops the pending aux_rvalid; no response is issued after reset release.

Configuration
REQ-036 Macro DMEM_ARBITER_STATS_EN defined: stat_stall_cnt counts core_stall cycles and stat_aux_cnt counts aux grants, both 16-bit saturating and reset to 0.
REQ-037 DMEM_ARBITER_STATS_EN undefined: stat outputs are tied to 0, no counter logic is present, and all other behaviour is identical.

Verification
REQ-038 Core-only: core_req=1, we=1, addr=0x10, wdata=0xDEADBEEF -> d_write_en=1, d_addr=0x10, core_stall=0.
REQ-039 Aux-only read of 0x20 holding 0x12345678 -> aux_ready=1; next cycle aux_rvalid=1, aux_rdata=0x12345678.
REQ-040 core_req and aux_valid held continuously (defaults) -> aux is denied for 8 cycles, then wins 4 consecutive grants with core_stall=1, then the cycle repeats.
REQ-041 Reset asserted the cycle after an accepted aux read -> aux_rvalid stays 0; state is CORE_PRI after release.
REQ-042 STATS_EN defined, REQ-040 stimulus for 24 cycles -> stat_stall_cnt=8, stat_aux_cnt=8; undefined -> both 0.
